// File: rtl/ecdh_des_pkg.sv
// Shared definitions for the ECC-DH / 3DES sequencer.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - error codes reported on err_code
//   - default key widths and a small max helper used to size the shared counter
package ecdh_des_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ECC_RUN   = 3'd1;
   localparam logic [2:0] ST_ECC_DONE  = 3'd2;
   localparam logic [2:0] ST_KEY_LOAD  = 3'd3;
   localparam logic [2:0] ST_INIT_WAIT = 3'd4;
   localparam logic [2:0] ST_DATA      = 3'd5;
   localparam logic [2:0] ST_DRAIN     = 3'd6;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_NOKEY   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   // keys = {sec_x, low DEF_SEC_Y_W bits of sec_y}
   localparam int unsigned DEF_KEY_W      = 163;
   localparam int unsigned DEF_SESS_KEY_W = 192;
   localparam int unsigned DEF_SEC_Y_W    = DEF_SESS_KEY_W - DEF_KEY_W;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ecdh_des_sequencer_counter.sv
// Loadable down-counter shared by all timed sequencer states.
//   clk, n_rst : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : counter currently holds 0 (it stops there)
module seq_down_counter #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ecdh_des_sequencer.sv
// Top-level ECC-DH / 3DES sequencer.
// Arbitrates NUM_SLOTS ECC point-multiply requests onto one ECC core, captures the public
// key (slot 0) or shared secret (other slots), exposes a registered session key and walks
// the 3DES key-load / fill / stream / drain phases.
//   ecc_start/estart/edone/Pox/Poy : request channels and ECC core handshake
//   des_start/des_mode/key_clear   : DES request, mode, secret wipe
//   keys/is_encrypt/key_valid      : session key, latched mode, secret-held flag
//   pub_x/pub_y                    : public key
//   ecc_done/des_done/busy         : status
//   err_valid/err_code             : error pulse and sticky code
module ecdh_des_sequencer
   import ecdh_des_pkg::*;
#(
   parameter int unsigned KEY_W       = DEF_KEY_W,
   parameter int unsigned SESS_KEY_W  = DEF_SESS_KEY_W,
   parameter int unsigned NUM_SLOTS   = 2,
   parameter int unsigned DES_LAT     = 48,
   parameter int unsigned KEYLOAD_CYC = 2,
   parameter int unsigned ECC_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [NUM_SLOTS-1:0]  ecc_start,
   input  logic                  des_start,
   input  logic                  des_mode,
   input  logic                  key_clear,
   output logic                  estart,
   input  logic [KEY_W-1:0]      Pox,
   input  logic [KEY_W-1:0]      Poy,
   input  logic                  edone,
   output logic [SESS_KEY_W-1:0] keys,
   output logic                  is_encrypt,
   output logic                  key_valid,
   output logic [KEY_W-1:0]      pub_x,
   output logic [KEY_W-1:0]      pub_y,
   output logic [NUM_SLOTS-1:0]  ecc_done,
   output logic                  des_done,
   output logic                  busy,
   output logic                  err_valid,
   output logic [1:0]            err_code
);

   localparam int unsigned SEC_Y_W = SESS_KEY_W - KEY_W;
   localparam int unsigned SLOT_W  = $clog2(NUM_SLOTS);
   localparam int unsigned CNT_W   = $clog2(max3(DES_LAT, KEYLOAD_CYC, ECC_TIMEOUT) + 1);

   // Counter preloads are N-1 so the state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LOAD_ECC = (ECC_TIMEOUT > 0) ? CNT_W'(ECC_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] LOAD_KEY = CNT_W'(KEYLOAD_CYC - 1);
   localparam logic [CNT_W-1:0] LOAD_DES = CNT_W'(DES_LAT - 1);

   logic [2:0]         state_q, state_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [KEY_W-1:0]   pub_x_q, pub_x_d, pub_y_q, pub_y_d, sec_x_q, sec_x_d;
   logic [SEC_Y_W-1:0] sec_y_q, sec_y_d;
   logic               key_valid_q, key_valid_d;
   logic               is_enc_q, is_enc_d;
   logic               err_valid_q, err_valid_d;
   logic [1:0]         err_code_q, err_code_d;

   logic               cnt_load, cnt_zero;
   logic [CNT_W-1:0]   cnt_val;
   logic               req_any;
   logic [SLOT_W-1:0]  req_slot;

   // Lowest-index request wins: scan downwards so the last hit is the lowest index.
   always_comb begin
      req_any  = 1'b0;
      req_slot = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (ecc_start[i]) begin
            req_any  = 1'b1;
            req_slot = SLOT_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      pub_x_d     = pub_x_q;
      pub_y_d     = pub_y_q;
      sec_x_d     = sec_x_q;
      sec_y_d     = sec_y_q;
      key_valid_d = key_valid_q;
      is_enc_d    = is_enc_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               slot_d   = req_slot;
               state_d  = ST_ECC_RUN;
               cnt_load = 1'b1;
               cnt_val  = LOAD_ECC;
            end else if (des_start) begin
               if (key_valid_q) begin
                  is_enc_d = des_mode;
                  state_d  = ST_KEY_LOAD;
                  cnt_load = 1'b1;
                  cnt_val  = LOAD_KEY;
               end else begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_NOKEY;
               end
            end else if (key_clear) begin
               sec_x_d     = '0;
               sec_y_d     = '0;
               key_valid_d = 1'b0;
            end
         end
         ST_ECC_RUN: begin
            // edone takes precedence over a timeout expiring in the same cycle
            if (edone) begin
               state_d = ST_ECC_DONE;
               if (slot_q == '0) begin
                  pub_x_d = Pox;
                  pub_y_d = Poy;
               end else begin
                  sec_x_d     = Pox;
                  sec_y_d     = Poy[SEC_Y_W-1:0];
                  key_valid_d = 1'b1;
               end
            end else if ((ECC_TIMEOUT > 0) && cnt_zero) begin
               state_d     = ST_IDLE;
               err_valid_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_ECC_DONE: state_d = ST_IDLE;
         ST_KEY_LOAD: begin
            if (cnt_zero) begin
               state_d  = ST_INIT_WAIT;
               cnt_load = 1'b1;
               cnt_val  = LOAD_DES;
            end
         end
         ST_INIT_WAIT: begin
            if (cnt_zero) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (!des_start) begin
               state_d  = ST_DRAIN;
               cnt_load = 1'b1;
               cnt_val  = LOAD_DES;
            end
         end
         ST_DRAIN: begin
            if (cnt_zero) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         pub_x_q     <= '0;
         pub_y_q     <= '0;
         sec_x_q     <= '0;
         sec_y_q     <= '0;
         key_valid_q <= 1'b0;
         is_enc_q    <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         pub_x_q     <= pub_x_d;
         pub_y_q     <= pub_y_d;
         sec_x_q     <= sec_x_d;
         sec_y_q     <= sec_y_d;
         key_valid_q <= key_valid_d;
         is_enc_q    <= is_enc_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   seq_down_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   assign estart     = (state_q == ST_ECC_RUN);
   assign busy       = (state_q != ST_IDLE);
   assign des_done   = (state_q == ST_DATA) || (state_q == ST_DRAIN);
   assign ecc_done   = (state_q == ST_ECC_DONE) ?
                       ({{(NUM_SLOTS - 1){1'b0}}, 1'b1} << slot_q) : '0;
   assign keys       = {sec_x_q, sec_y_q};
   assign is_encrypt = is_enc_q;
   assign key_valid  = key_valid_q;
   assign pub_x      = pub_x_q;
   assign pub_y      = pub_y_q;
   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_ecdh_des_sequencer.sv
// Self-checking bench for ecdh_des_sequencer (ECC_TIMEOUT=20, other parameters default).
// Directed table, hand-written corner sequences, then random transactions checked against
// a transaction-level model of the key/error registers and phase lengths.
module tb_ecdh_des_sequencer;

   localparam int K  = 2;
   localparam int L  = 48;
   localparam int TO = 20;
   localparam int KW = 163;
   localparam int SW = 192;
   localparam int YW = SW - KW;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [1:0]    ecc_start = '0;
   logic          des_start = 1'b0, des_mode = 1'b0, key_clear = 1'b0, edone = 1'b0;
   logic [KW-1:0] Pox = '0, Poy = '0;
   logic          estart, is_encrypt, key_valid, des_done, busy, err_valid;
   logic [SW-1:0] keys;
   logic [KW-1:0] pub_x, pub_y;
   logic [1:0]    ecc_done, err_code;

   ecdh_des_sequencer #(
      .KEY_W       (KW),
      .SESS_KEY_W  (SW),
      .NUM_SLOTS   (2),
      .DES_LAT     (L),
      .KEYLOAD_CYC (K),
      .ECC_TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .ecc_start  (ecc_start),
      .des_start  (des_start),
      .des_mode   (des_mode),
      .key_clear  (key_clear),
      .estart     (estart),
      .Pox        (Pox),
      .Poy        (Poy),
      .edone      (edone),
      .keys       (keys),
      .is_encrypt (is_encrypt),
      .key_valid  (key_valid),
      .pub_x      (pub_x),
      .pub_y      (pub_y),
      .ecc_done   (ecc_done),
      .des_done   (des_done),
      .busy       (busy),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of architecturally visible registers
   logic [KW-1:0] m_pub_x = '0, m_pub_y = '0, m_sec_x = '0;
   logic [YW-1:0] m_sec_y = '0;
   logic          m_kv = 1'b0, m_enc = 1'b0;
   logic [1:0]    m_err = 2'd0;

   typedef struct {
      int            op;       // 0 ecc, 1 des, 2 clear
      int            slot;
      int            lat;      // edone cycle within ECC run (> TO: never)
      logic [KW-1:0] x;
      logic [KW-1:0] y;
      logic          mode;
      int            drop;     // DES-sequence cycle index at which des_start goes low
      int            exp_est;  // expected estart cycles
      logic [1:0]    exp_err;
      int            exp_data; // expected DATA cycles
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [KW-1:0] rnd_key();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[KW-1:0];
   endfunction

   task automatic check_regs(input string tag);
      check({tag, ".pub_x"}, 256'(pub_x), 256'(m_pub_x));
      check({tag, ".pub_y"}, 256'(pub_y), 256'(m_pub_y));
      check({tag, ".keys"}, 256'(keys), 256'({m_sec_x, m_sec_y}));
      check({tag, ".key_valid"}, 256'(key_valid), 256'(m_kv));
      check({tag, ".err_code"}, 256'(err_code), 256'(m_err));
      check({tag, ".is_encrypt"}, 256'(is_encrypt), 256'(m_enc));
      check({tag, ".busy_idle"}, 256'(busy), 256'(0));
   endtask

   task automatic run_ecc(input logic [1:0] mask, input int slot, input int lat,
                          input logic [KW-1:0] x, input logic [KW-1:0] y,
                          input int exp_est, input logic [1:0] exp_err);
      int cnt;
      ecc_start = mask;
      tick();
      ecc_start = mask & ~(2'b01 << slot);
      cnt = 0;
      while (estart === 1'b1 && cnt < 40) begin
         cnt++;
         if (cnt == lat) begin
            edone = 1'b1;
            Pox   = x;
            Poy   = y;
         end
         tick();
         edone = 1'b0;
         Pox   = rnd_key();
         Poy   = rnd_key();
      end
      check("ecc.estart_cycles", 256'(cnt), 256'(exp_est));
      if (exp_err == 2'd0) begin
         check("ecc.done_pulse", 256'(ecc_done), 256'(2'b01 << slot));
         check("ecc.no_err", 256'(err_valid), 256'(0));
         if (slot == 0) begin
            m_pub_x = x;
            m_pub_y = y;
         end else begin
            m_sec_x = x;
            m_sec_y = y[YW-1:0];
            m_kv    = 1'b1;
         end
         tick();
         check("ecc.done_clear", 256'(ecc_done), 256'(0));
      end else begin
         check("ecc.timeout_err", 256'(err_valid), 256'(1));
         check("ecc.timeout_nodone", 256'(ecc_done), 256'(0));
         m_err = exp_err;
         tick();
         check("ecc.err_pulse_end", 256'(err_valid), 256'(0));
      end
      check_regs("ecc");
   endtask

   task automatic run_des(input logic mode, input int drop, input int exp_data);
      int i, busy_cnt, dd_cnt, first_dd, kbad;
      des_start = 1'b1;
      des_mode  = mode;
      tick();
      des_mode = ~mode;  // must be ignored once accepted
      i = 0; busy_cnt = 0; dd_cnt = 0; first_dd = 0; kbad = 0;
      while (busy === 1'b1 && i < 400) begin
         i++;
         busy_cnt++;
         if (des_done === 1'b1) begin
            dd_cnt++;
            if (first_dd == 0) first_dd = i;
         end
         if (keys !== {m_sec_x, m_sec_y} || is_encrypt !== mode) kbad++;
         des_start = (i < drop);
         Pox = rnd_key();
         Poy = rnd_key();
         tick();
      end
      des_start = 1'b0;
      m_enc = mode;
      check("des.busy_cycles", 256'(busy_cnt), 256'(K + L + exp_data + L));
      check("des.done_cycles", 256'(dd_cnt), 256'(exp_data + L));
      check("des.first_data", 256'(first_dd), 256'(K + L + 1));
      check("des.keys_mode_stable", 256'(kbad), 256'(0));
      check_regs("des");
   endtask

   task automatic run_nokey();
      des_start = 1'b1;
      tick();
      check("nokey.err_valid", 256'(err_valid), 256'(1));
      check("nokey.err_code", 256'(err_code), 256'(1));
      check("nokey.busy", 256'(busy), 256'(0));
      tick();
      check("nokey.refire", 256'(err_valid), 256'(1));
      des_start = 1'b0;
      tick();
      check("nokey.pulse_end", 256'(err_valid), 256'(0));
      m_err = 2'd1;
      check_regs("nokey");
   endtask

   task automatic run_clear();
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      m_sec_x = '0;
      m_sec_y = '0;
      m_kv    = 1'b0;
      check_regs("clear");
   endtask

   initial begin
      tbl[0] = '{0, 0, 10, 163'h1A, 163'h2B, 1'b0, 0, 10, 2'd0, 0};
      tbl[1] = '{0, 1, 7, 163'h5_1234_5678_9ABC_DEF0_1122_3344_5566_7788_99AA_BBCC,
                 163'h2_F0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F_A5A5_5A5A,
                 1'b0, 0, 7, 2'd0, 0};
      tbl[2] = '{1, 0, 0, '0, '0, 1'b1, K + L + 5, 0, 2'd0, 5};
      tbl[3] = '{0, 1, 20, 163'h7_0BAD_CAFE, 163'h3_FEED_F00D_1357_9BDF, 1'b0, 0, 20, 2'd0, 0};
      tbl[4] = '{0, 0, 30, 163'h6_6666, 163'h7_7777, 1'b0, 0, 20, 2'd2, 0};
      tbl[5] = '{1, 0, 0, '0, '0, 1'b0, 1, 0, 2'd0, 1};
      tbl[6] = '{2, 0, 0, '0, '0, 1'b0, 0, 0, 2'd0, 0};

      // Reset state
      #1;
      check("rst.busy", 256'(busy), 256'(0));
      check("rst.keys", 256'(keys), 256'(0));
      check("rst.err_code", 256'(err_code), 256'(0));
      check("rst.estart", 256'(estart), 256'(0));
      repeat (2) @(posedge clk);
      #2 n_rst = 1'b1;
      tick();
      check_regs("rst");

      // Directed table
      for (int v = 0; v < 7; v++) begin
         case (tbl[v].op)
            0: run_ecc(2'b01 << tbl[v].slot, tbl[v].slot, tbl[v].lat, tbl[v].x, tbl[v].y,
                       tbl[v].exp_est, tbl[v].exp_err);
            1: run_des(tbl[v].mode, tbl[v].drop, tbl[v].exp_data);
            default: run_clear();
         endcase
      end

      // No key held: error, no state change
      run_nokey();

      // Simultaneous requests: slot 0 first, slot 1 after return to IDLE
      run_ecc(2'b11, 0, 4, 163'h44, 163'h55, 4, 2'd0);
      check("arb.slot1_pending", 256'(ecc_start), 256'(2'b10));
      run_ecc(2'b10, 1, 5, 163'h1_0101, 163'h2_0202, 5, 2'd0);

      // Reset in the middle of INIT_WAIT
      des_start = 1'b1;
      des_mode  = 1'b1;
      tick();
      repeat (20) tick();
      #2 n_rst = 1'b0;
      #1;
      check("amid.busy", 256'(busy), 256'(0));
      check("amid.des_done", 256'(des_done), 256'(0));
      check("amid.key_valid", 256'(key_valid), 256'(0));
      check("amid.keys", 256'(keys), 256'(0));
      check("amid.is_encrypt", 256'(is_encrypt), 256'(0));
      check("amid.pub_x", 256'(pub_x), 256'(0));
      des_start = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      m_pub_x = '0; m_pub_y = '0; m_sec_x = '0; m_sec_y = '0;
      m_kv = 1'b0; m_enc = 1'b0; m_err = 2'd0;
      tick();
      check_regs("amid");

      // Random transactions
      for (int t = 0; t < 30; t++) begin
         int r, s, lat, drop, dc;
         r = $urandom_range(0, 9);
         if (r < 5) begin
            s   = $urandom_range(0, 1);
            lat = $urandom_range(1, 25);
            run_ecc(2'b01 << s, s, lat, rnd_key(), rnd_key(), (lat <= TO) ? lat : TO,
                    (lat <= TO) ? 2'd0 : 2'd2);
         end else if (r < 9) begin
            if (m_kv) begin
               drop = $urandom_range(1, K + L + 8);
               dc   = (drop - (K + L) > 1) ? drop - (K + L) : 1;
               run_des(1'($urandom_range(0, 1)), drop, dc);
            end else begin
               run_nokey();
            end
         end else begin
            run_clear();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
